// File: rtl/truth_table_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_pkg
// Shared definitions for the truth-table scanner: scan FSM state encoding,
// vector width / vector count, and the default per-vector settle time.
// ---------------------------------------------------------------------------
package truth_table_pkg;

  localparam int VEC_W                 = 4;
  localparam int NUM_VEC               = 16;
  localparam int DEFAULT_SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// 4-bit down-counter that measures how long a vector has been held.
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset (counter cleared to 0)
//   load       - reload the counter with load_value this cycle
//   load_value - reload value (settle cycles minus one)
//   expired    - counter has reached zero
// ---------------------------------------------------------------------------
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_value,
  output logic       expired
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Load wins over counting; the counter parks at zero rather than wrapping
  // so that "expired" stays asserted until the next reload.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 4'd0);

endmodule

// File: rtl/truth_table_scanner.sv
// ---------------------------------------------------------------------------
// truth_table_scanner
// Drives the four inputs of an external combinational block through all 16
// combinations, waits SETTLE_CYCLES per vector, samples the block's output
// into a truth-table register and reports table, ones count and a compare
// against EXPECTED.
// Parameters:
//   SETTLE_CYCLES - cycles each vector is held before sampling (1..15)
//   EXPECTED      - golden truth table, bit n = expected e for vector n
// Ports:
//   clk, rst      - clock / asynchronous active-high reset
//   start         - scan request, only honoured in IDLE
//   e             - output of the block under scan
//   a, b, c, d    - registered stimulus vector, a is the MSB
//   busy          - scan in progress (start accepted until done)
//   done          - one-cycle completion pulse
//   truth_table   - captured table, bit n = e for {a,b,c,d} = n
//   ones_count    - number of vectors with e = 1 (0..16)
//   pass          - truth_table == EXPECTED, valid from done until next scan
// ---------------------------------------------------------------------------
module truth_table_scanner
  import truth_table_pkg::*;
#(
  parameter int          SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter logic [15:0] EXPECTED      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        e,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth_table,
  output logic [4:0]  ones_count,
  output logic        pass
);

  localparam logic [3:0]       RELOAD   = 4'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VEC - 1);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [NUM_VEC-1:0] table_q, table_d;
  logic [4:0]         ones_q, ones_d;
  logic               pass_q, pass_d;
  logic               timer_load;
  logic               timer_expired;

  settle_timer u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (RELOAD),
    .expired    (timer_expired)
  );

  // Scan sequencing. The settle timer is reloaded whenever a new vector is
  // launched (start acceptance and every non-final capture), so each vector
  // is held SETTLE_CYCLES cycles in SETTLE plus one cycle in CAPTURE.
  // pass is computed from table_d on the way into DONE so that it already
  // includes the vector-15 capture and is valid alongside the done pulse.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    table_d    = table_q;
    ones_d     = ones_q;
    pass_d     = pass_q;
    timer_load = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          table_d    = '0;
          ones_d     = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (timer_expired) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        table_d[idx_q] = e;
        ones_d         = ones_q + {4'b0000, e};
        if (idx_q == LAST_IDX) begin
          pass_d  = (table_d == EXPECTED);
          state_d = DONE;
        end else begin
          idx_d      = idx_q + 1'b1;
          timer_load = 1'b1;
          state_d    = SETTLE;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The stimulus register follows the next state so the new vector appears
  // on the same edge the FSM launches it; outside a sweep it rests at zero.
  always_comb begin
    vec_d = '0;
    if (state_d == SETTLE || state_d == CAPTURE) begin
      vec_d = idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      table_q <= '0;
      ones_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      table_q <= table_d;
      ones_q  <= ones_d;
      pass_q  <= pass_d;
    end
  end

  assign {a, b, c, d}  = vec_q;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign truth_table   = table_q;
  assign ones_count    = ones_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// ---------------------------------------------------------------------------
// tb_truth_table_scanner
// Two scanner instances (S=2 with EXPECTED=16'h8000, S=1 with
// EXPECTED=16'hAAAA) each wrapped around a table-driven stub for Ex1.
// Expected results come from the stub's function table: the captured table
// is the function itself, ones_count its population count, and done lands
// 16*(S+1) edges after start acceptance.
// ---------------------------------------------------------------------------
module tb_truth_table_scanner;

  localparam logic [15:0] EXP0 = 16'h8000;
  localparam logic [15:0] EXP1 = 16'hAAAA;

  logic        clk;
  logic        rst;
  logic [1:0]  start_s;
  logic [1:0]  e_s;
  logic [1:0]  a_s, b_s, c_s, d_s;
  logic [1:0]  busy_s, done_s, pass_s;
  logic [15:0] tab_s  [2];
  logic [4:0]  ones_s [2];
  logic [15:0] func_s [2];

  int compared;
  int mismatched;

  truth_table_scanner #(.SETTLE_CYCLES(2), .EXPECTED(EXP0)) dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .e(e_s[0]),
    .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .d(d_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .truth_table(tab_s[0]),
    .ones_count(ones_s[0]), .pass(pass_s[0])
  );

  truth_table_scanner #(.SETTLE_CYCLES(1), .EXPECTED(EXP1)) dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .e(e_s[1]),
    .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .d(d_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .truth_table(tab_s[1]),
    .ones_count(ones_s[1]), .pass(pass_s[1])
  );

  // Ex1 stand-ins: e is simply the stub's function table indexed by the vector
  assign e_s[0] = func_s[0][{a_s[0], b_s[0], c_s[0], d_s[0]}];
  assign e_s[1] = func_s[1][{a_s[1], b_s[1], c_s[1], d_s[1]}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popcount16(input logic [15:0] v);
    int n;
    n = 0;
    for (int k = 0; k < 16; k++) n += int'(v[k]);
    return n;
  endfunction

  function automatic logic [3:0] vec_of(input int i);
    return {a_s[i], b_s[i], c_s[i], d_s[i]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One full scan on instance i with stub function f; optionally re-pulses
  // start mid-scan, which must be ignored.
  task automatic applyStimulus(input int i, input logic [15:0] f, input bit repulse);
    int s, total, done_edge, done_cnt, vec_bad, busy_bad, exp_vec;
    logic pass_at_done;
    logic [15:0] exp_tab;
    s = (i == 0) ? 2 : 1;
    total = 16 * (s + 1);
    exp_tab = f;
    done_edge = -1; done_cnt = 0; vec_bad = 0; busy_bad = 0; pass_at_done = 1'bx;
    @(negedge clk);
    func_s[i]  = f;
    start_s[i] = 1'b1;
    for (int k = 0; k <= total + 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) start_s[i] = 1'b0;
      if (repulse && k == 10) start_s[i] = 1'b1;
      if (repulse && k == 11) start_s[i] = 1'b0;
      if (k < total) begin
        exp_vec = k / (s + 1);
        if (vec_of(i) !== exp_vec[3:0]) vec_bad++;
        if (busy_s[i] !== 1'b1) busy_bad++;
      end
      if (k > total && busy_s[i] !== 1'b0) busy_bad++;
      if (done_s[i] === 1'b1) begin
        if (done_cnt == 0) begin
          done_edge = k;
          pass_at_done = pass_s[i];
        end
        done_cnt++;
      end
    end
    checkOutput($sformatf("done_edge_i%0d", i), 32'(done_edge), 32'(total));
    checkOutput($sformatf("done_count_i%0d", i), 32'(done_cnt), 32'd1);
    checkOutput($sformatf("vector_seq_i%0d", i), 32'(vec_bad), 32'd0);
    checkOutput($sformatf("busy_window_i%0d", i), 32'(busy_bad), 32'd0);
    checkOutput($sformatf("table_i%0d", i), {16'h0, tab_s[i]}, {16'h0, exp_tab});
    checkOutput($sformatf("ones_i%0d", i), {27'h0, ones_s[i]}, 32'(popcount16(f)));
    checkOutput($sformatf("pass_i%0d", i), {31'h0, pass_s[i]},
                {31'h0, (f == ((i == 0) ? EXP0 : EXP1))});
    checkOutput($sformatf("pass_at_done_i%0d", i), {31'h0, pass_at_done},
                {31'h0, (f == ((i == 0) ? EXP0 : EXP1))});
  endtask

  initial begin : main
    int busy_seen;
    int d1, d2, ndone;
    logic [15:0] f2;
    compared = 0;
    mismatched = 0;
    rst = 1'b1;
    start_s = 2'b00;
    func_s[0] = 16'h0000;
    func_s[1] = 16'h0000;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy_s !== 2'b00) busy_seen++;
    end
    checkOutput("idle_busy_never", 32'(busy_seen), 32'd0);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("reset_vec_i%0d", i), {28'h0, vec_of(i)}, 32'h0);
      checkOutput($sformatf("reset_done_i%0d", i), {31'h0, done_s[i]}, 32'h0);
      checkOutput($sformatf("reset_table_i%0d", i), {16'h0, tab_s[i]}, 32'h0);
      checkOutput($sformatf("reset_ones_i%0d", i), {27'h0, ones_s[i]}, 32'h0);
      checkOutput($sformatf("reset_pass_i%0d", i), {31'h0, pass_s[i]}, 32'h0);
    end

    // Directed functions
    $display("[TB] AND stub, S=2");
    applyStimulus(0, 16'h8000, 1'b0);
    $display("[TB] e=d stub, S=1");
    applyStimulus(1, 16'hAAAA, 1'b0);
    $display("[TB] e=1 stub, no wrap of ones_count");
    applyStimulus(0, 16'hFFFF, 1'b0);
    applyStimulus(1, 16'h0000, 1'b0);

    // Randomised functions, with start re-pulsed while busy on some scans
    for (int r = 0; r < 4; r++) begin
      applyStimulus(r % 2, 16'($urandom), 1'(r >= 2));
    end

    // Reset mid-scan
    $display("[TB] reset mid-scan");
    @(negedge clk);
    func_s[0]  = 16'hFFFF;
    start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("midscan_partial_table", {16'h0, tab_s[0]}, 32'h003F);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midscan_vec", {28'h0, vec_of(0)}, 32'h0);
    checkOutput("midscan_busy", {31'h0, busy_s[0]}, 32'h0);
    checkOutput("midscan_table", {16'h0, tab_s[0]}, 32'h0);
    checkOutput("midscan_ones", {27'h0, ones_s[0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 16'($urandom), 1'b0);

    // start stuck high: back-to-back scans with one IDLE cycle between
    $display("[TB] start held high");
    f2 = 16'($urandom) | 16'h0001;
    d1 = -1; d2 = -1; ndone = 0;
    @(negedge clk);
    func_s[0]  = 16'hFFFF;
    start_s[0] = 1'b1;
    for (int k = 0; k <= 110; k++) begin
      @(posedge clk); #1;
      if (done_s[0] === 1'b1) begin
        if (ndone == 0) d1 = k;
        else if (ndone == 1) d2 = k;
        ndone++;
      end
      if (k == 49) begin
        checkOutput("stuck_idle_gap", {31'h0, busy_s[0]}, 32'h0);
        func_s[0] = f2;
      end
      if (k == 50) begin
        checkOutput("stuck_reaccept_busy", {31'h0, busy_s[0]}, 32'h1);
        checkOutput("stuck_table_cleared", {16'h0, tab_s[0]}, 32'h0);
      end
      if (k == 99) start_s[0] = 1'b0;
    end
    checkOutput("stuck_done1_edge", 32'(d1), 32'd48);
    checkOutput("stuck_done2_edge", 32'(d2), 32'd98);
    checkOutput("stuck_done_count", 32'(ndone), 32'd2);
    checkOutput("stuck_table2", {16'h0, tab_s[0]}, {16'h0, f2});
    checkOutput("stuck_ones2", {27'h0, ones_s[0]}, 32'(popcount16(f2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
